// File: rtl/wakeup_issue_queue.sv
// Out-of-order issue queue: holds renamed uops until both sources wake, issues the oldest ready one; stores issue in order.
// Dispatch-to-issue is one cycle minimum; disp_ready falls on full, issue_* holds stable while issue_ready is low.
module wakeup_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 32,
    parameter int CDB_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [TAG_W-1:0]             disp_src1_tag,
    input  logic                         disp_src1_rdy,
    input  logic [TAG_W-1:0]             disp_src2_tag,
    input  logic                         disp_src2_rdy,
    input  logic [TAG_W-1:0]             disp_dst_tag,
    input  logic                         disp_is_store,
    input  logic [PAYLOAD_W-1:0]         disp_payload,
    input  logic [CDB_PORTS-1:0]         cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0]   cdb_tag,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [TAG_W-1:0]             issue_dst_tag,
    output logic                         issue_is_store,
    output logic [PAYLOAD_W-1:0]         issue_payload,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0]     src1_tag;
        logic                 src1_rdy;
        logic [TAG_W-1:0]     src2_tag;
        logic                 src2_rdy;
        logic [TAG_W-1:0]     dst_tag;
        logic                 is_store;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t           ent   [DEPTH];
    logic [DEPTH-1:0] vld;
    // older[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0] older [DEPTH];
    logic [CNT_W-1:0] occ_q;
    logic             locked;
    logic [IDX_W-1:0] lock_idx;

    logic [DEPTH-1:0] elig;
    logic             sel_any;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic             store_blk;
    logic             beaten;
    logic             disp_fire;
    logic             issue_fire;
    entry_t           new_ent;

    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Eligibility and oldest-first select; a store waits behind any older valid store
    always_comb begin
        elig      = '0;
        sel_any   = 1'b0;
        sel_idx   = '0;
        store_blk = 1'b0;
        beaten    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            store_blk = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && vld[j] && ent[j].is_store && older[j][i]) begin
                    store_blk = 1'b1;
                end
            end
            elig[i] = vld[i] && ent[i].src1_rdy && ent[i].src2_rdy &&
                      !(ent[i].is_store && store_blk);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (elig[i]) begin
                beaten = 1'b0;
                for (int j = 0; j < DEPTH; j++) begin
                    if ((j != i) && elig[j] && older[j][i]) begin
                        beaten = 1'b1;
                    end
                end
                if (!beaten && !sel_any) begin
                    sel_any = 1'b1;
                    sel_idx = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!vld[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Sources matching a same-cycle broadcast are captured ready, so no wakeup is lost
    always_comb begin
        new_ent.src1_tag = disp_src1_tag;
        new_ent.src1_rdy = disp_src1_rdy | cdb_hit(disp_src1_tag);
        new_ent.src2_tag = disp_src2_tag;
        new_ent.src2_rdy = disp_src2_rdy | cdb_hit(disp_src2_tag);
        new_ent.dst_tag  = disp_dst_tag;
        new_ent.is_store = disp_is_store;
        new_ent.payload  = disp_payload;
    end

    assign disp_ready     = (occ_q < CNT_W'(DEPTH));
    assign occupancy      = occ_q;
    assign issue_idx      = locked ? lock_idx : sel_idx;
    assign issue_valid    = locked | sel_any;
    assign issue_dst_tag  = issue_valid ? ent[issue_idx].dst_tag  : '0;
    assign issue_is_store = issue_valid ? ent[issue_idx].is_store : 1'b0;
    assign issue_payload  = issue_valid ? ent[issue_idx].payload  : '0;
    assign disp_fire      = disp_valid && disp_ready;
    assign issue_fire     = issue_valid && issue_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i]   <= '0;
                older[i] <= '0;
            end
        end else if (flush) begin
            vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_hit(ent[i].src1_tag)) ent[i].src1_rdy <= 1'b1;
                if (cdb_hit(ent[i].src2_tag)) ent[i].src2_rdy <= 1'b1;
            end
            if (issue_fire) begin
                vld[issue_idx] <= 1'b0;
            end
            if (disp_fire) begin
                ent[free_idx]   <= new_ent;
                vld[free_idx]   <= 1'b1;
                older[free_idx] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    older[j][free_idx] <= (j != int'(free_idx));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
        end
    end

    // A stalled presentation pins the chosen entry so issue_* cannot change under the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked   <= 1'b0;
            lock_idx <= '0;
        end else if (flush || issue_fire) begin
            locked   <= 1'b0;
        end else if (issue_valid && !issue_ready) begin
            locked   <= 1'b1;
            lock_idx <= issue_idx;
        end
    end

endmodule

// File: tb/tb_wakeup_issue_queue.sv
// Directed bench for wakeup_issue_queue: vector table plus hand sequences for fill, lock and flush.
module tb_wakeup_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [5:0]  disp_src1_tag;
    logic        disp_src1_rdy;
    logic [5:0]  disp_src2_tag;
    logic        disp_src2_rdy;
    logic [5:0]  disp_dst_tag;
    logic        disp_is_store;
    logic [31:0] disp_payload;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_tag;
    logic        issue_valid;
    logic        issue_ready;
    logic [5:0]  issue_dst_tag;
    logic        issue_is_store;
    logic [31:0] issue_payload;
    logic [3:0]  occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wakeup_issue_queue #(.DEPTH(8), .TAG_W(6), .PAYLOAD_W(32), .CDB_PORTS(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
        .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy),
        .disp_dst_tag(disp_dst_tag), .disp_is_store(disp_is_store),
        .disp_payload(disp_payload),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_dst_tag(issue_dst_tag), .issue_is_store(issue_is_store),
        .issue_payload(issue_payload), .occupancy(occupancy)
    );

    typedef struct {
        logic        dv;
        logic [5:0]  s1t;
        logic        s1r;
        logic [5:0]  dst;
        logic        st;
        logic [31:0] pl;
        logic [1:0]  cv;
        logic [5:0]  ct0;
        logic [5:0]  ct1;
        logic        ir;
        logic        eiv;
        logic [5:0]  edst;
        logic [31:0] epl;
        logic [3:0]  eocc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic dv, input logic [5:0] s1t, input logic s1r,
                                input logic [5:0] dst, input logic st, input logic [31:0] pl,
                                input logic [1:0] cv, input logic [5:0] ct0, input logic [5:0] ct1,
                                input logic ir, input logic eiv, input logic [5:0] edst,
                                input logic [31:0] epl, input logic [3:0] eocc);
        vec_t v;
        v.dv = dv; v.s1t = s1t; v.s1r = s1r; v.dst = dst; v.st = st; v.pl = pl;
        v.cv = cv; v.ct0 = ct0; v.ct1 = ct1; v.ir = ir;
        v.eiv = eiv; v.edst = edst; v.epl = epl; v.eocc = eocc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        disp_valid = 1'b0; disp_src1_tag = '0; disp_src1_rdy = 1'b1;
        disp_src2_tag = '0; disp_src2_rdy = 1'b1; disp_dst_tag = '0;
        disp_is_store = 1'b0; disp_payload = '0; cdb_valid = '0; cdb_tag = '0;
        issue_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic disp(input logic [5:0] s1t, input logic s1r, input logic [5:0] dst,
                        input logic [31:0] pl);
        disp_valid = 1'b1; disp_src1_tag = s1t; disp_src1_rdy = s1r;
        disp_dst_tag = dst; disp_payload = pl; disp_is_store = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_dst", 32'(issue_dst_tag), 32'd0);
        chk("rst_payload", issue_payload, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic issue
        vq.push_back(mk(1, 6'd0, 1, 6'd10, 0, 32'h100, 2'b00, 6'd0, 6'd0, 1, 0, 6'd0,  32'h0,   4'd0));
        vq.push_back(mk(0, 6'd0, 1, 6'd0,  0, 32'h0,   2'b00, 6'd0, 6'd0, 1, 1, 6'd10, 32'h100, 4'd1));
        vq.push_back(mk(0, 6'd0, 1, 6'd0,  0, 32'h0,   2'b00, 6'd0, 6'd0, 1, 0, 6'd0,  32'h0,   4'd0));
        // Younger ready uop overtakes, older one wakes from CDB port 0
        vq.push_back(mk(1, 6'd5, 0, 6'd11, 0, 32'hA,   2'b00, 6'd0, 6'd0, 0, 0, 6'd0,  32'h0,   4'd0));
        vq.push_back(mk(1, 6'd0, 1, 6'd12, 0, 32'hB,   2'b00, 6'd0, 6'd0, 1, 0, 6'd0,  32'h0,   4'd1));
        vq.push_back(mk(0, 6'd0, 1, 6'd0,  0, 32'h0,   2'b00, 6'd0, 6'd0, 1, 1, 6'd12, 32'hB,   4'd2));
        vq.push_back(mk(0, 6'd0, 1, 6'd0,  0, 32'h0,   2'b01, 6'd5, 6'd0, 1, 0, 6'd0,  32'h0,   4'd1));
        vq.push_back(mk(0, 6'd0, 1, 6'd0,  0, 32'h0,   2'b00, 6'd0, 6'd0, 1, 1, 6'd11, 32'hA,   4'd1));
        vq.push_back(mk(0, 6'd0, 1, 6'd0,  0, 32'h0,   2'b00, 6'd0, 6'd0, 1, 0, 6'd0,  32'h0,   4'd0));
        // Same-cycle wakeup on CDB port 1 during dispatch
        vq.push_back(mk(1, 6'd9, 0, 6'd13, 0, 32'hC,   2'b10, 6'd0, 6'd9, 1, 0, 6'd0,  32'h0,   4'd0));
        vq.push_back(mk(0, 6'd0, 1, 6'd0,  0, 32'h0,   2'b00, 6'd0, 6'd0, 1, 1, 6'd13, 32'hC,   4'd1));
        vq.push_back(mk(0, 6'd0, 1, 6'd0,  0, 32'h0,   2'b00, 6'd0, 6'd0, 1, 0, 6'd0,  32'h0,   4'd0));
        // Store ordering: ready younger store waits for older store
        vq.push_back(mk(1, 6'd3, 0, 6'd14, 1, 32'h50,  2'b00, 6'd0, 6'd0, 1, 0, 6'd0,  32'h0,   4'd0));
        vq.push_back(mk(1, 6'd0, 1, 6'd15, 1, 32'h51,  2'b00, 6'd0, 6'd0, 1, 0, 6'd0,  32'h0,   4'd1));
        vq.push_back(mk(0, 6'd0, 1, 6'd0,  0, 32'h0,   2'b00, 6'd0, 6'd0, 1, 0, 6'd0,  32'h0,   4'd2));
        vq.push_back(mk(0, 6'd0, 1, 6'd0,  0, 32'h0,   2'b01, 6'd3, 6'd0, 1, 0, 6'd0,  32'h0,   4'd2));
        vq.push_back(mk(0, 6'd0, 1, 6'd0,  0, 32'h0,   2'b00, 6'd0, 6'd0, 1, 1, 6'd14, 32'h50,  4'd2));
        vq.push_back(mk(0, 6'd0, 1, 6'd0,  0, 32'h0,   2'b00, 6'd0, 6'd0, 1, 1, 6'd15, 32'h51,  4'd1));
        vq.push_back(mk(0, 6'd0, 1, 6'd0,  0, 32'h0,   2'b00, 6'd0, 6'd0, 1, 0, 6'd0,  32'h0,   4'd0));

        for (int k = 0; k < vq.size(); k++) begin
            idle();
            disp_valid = vq[k].dv; disp_src1_tag = vq[k].s1t; disp_src1_rdy = vq[k].s1r;
            disp_dst_tag = vq[k].dst; disp_is_store = vq[k].st; disp_payload = vq[k].pl;
            cdb_valid = vq[k].cv; cdb_tag = {vq[k].ct1, vq[k].ct0}; issue_ready = vq[k].ir;
            chk($sformatf("vec%0d_issue_valid", k), 32'(issue_valid), 32'(vq[k].eiv));
            chk($sformatf("vec%0d_occupancy", k), 32'(occupancy), 32'(vq[k].eocc));
            chk($sformatf("vec%0d_disp_ready", k), 32'(disp_ready), 32'(vq[k].eocc < 4'd8));
            if (vq[k].eiv) begin
                chk($sformatf("vec%0d_dst", k), 32'(issue_dst_tag), 32'(vq[k].edst));
                chk($sformatf("vec%0d_payload", k), issue_payload, vq[k].epl);
            end
            tick();
        end

        // Fill all entries with waiting uops
        for (int i = 0; i < 8; i++) begin
            idle();
            disp(6'(20 + i), 1'b0, 6'(30 + i), 32'h200 + 32'(i));
            issue_ready = 1'b1;
            tick();
        end
        idle();
        chk("full_occupancy", 32'(occupancy), 32'd8);
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        chk("full_issue_valid", 32'(issue_valid), 32'd0);
        disp(6'd0, 1'b1, 6'd50, 32'h999);
        tick();
        chk("full_reject_occ", 32'(occupancy), 32'd8);
        idle();
        cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd22};
        tick();
        idle();
        disp(6'd0, 1'b1, 6'd51, 32'h998);
        issue_ready = 1'b1;
        chk("full_wake_valid", 32'(issue_valid), 32'd1);
        chk("full_wake_dst", 32'(issue_dst_tag), 32'd32);
        chk("full_wake_payload", issue_payload, 32'h202);
        chk("full_issue_no_bypass", 32'(disp_ready), 32'd0);
        tick();
        idle();
        chk("after_free_ready", 32'(disp_ready), 32'd1);
        chk("after_free_occ", 32'(occupancy), 32'd7);
        flush = 1'b1;
        tick();
        idle();
        chk("flush_full_occ", 32'(occupancy), 32'd0);
        chk("flush_full_valid", 32'(issue_valid), 32'd0);

        // Lock holds a younger uop while an older one wakes, then flush
        disp(6'd40, 1'b0, 6'd41, 32'h600);
        tick();
        idle();
        disp(6'd0, 1'b1, 6'd42, 32'h601);
        tick();
        idle();
        chk("hold_first_payload", issue_payload, 32'h601);
        tick();
        cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd40};
        chk("hold_wake_payload", issue_payload, 32'h601);
        tick();
        idle();
        chk("hold_after_wake_valid", 32'(issue_valid), 32'd1);
        chk("hold_after_wake_payload", issue_payload, 32'h601);
        chk("hold_after_wake_dst", 32'(issue_dst_tag), 32'd42);
        tick();
        chk("hold_later_payload", issue_payload, 32'h601);
        flush = 1'b1; issue_ready = 1'b1;
        disp(6'd0, 1'b1, 6'd43, 32'h602);
        tick();
        idle();
        chk("flush_hold_valid", 32'(issue_valid), 32'd0);
        chk("flush_hold_occ", 32'(occupancy), 32'd0);
        tick();
        chk("flush_settled_valid", 32'(issue_valid), 32'd0);
        chk("flush_settled_occ", 32'(occupancy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
